// File: rtl/accum_warp_looper_id_stage_pkg.sv
// Shared configuration constants for the accumulation warp looper slice.
// The id stage and its address calculator take their default widths from here.
package accum_warp_looper_id_stage_pkg;

  localparam int N_ICFG         = 3;
  localparam int GLOBAL_ADDR_BW = 16;
  localparam int WORK_BW        = 8;
  localparam int VDIM           = 2;

endpackage

// File: rtl/accum_warp_looper_linear_calc.sv
// Per-config linear address: base plus each block offset shifted into place.
// Purely combinational; the sum wraps modulo 2^ABW.
module accum_warp_looper_linear_calc #(
  parameter int ABW  = 16,
  parameter int WBW  = 8,
  parameter int VDIM = 2,
  parameter int SBW  = 4
) (
  input  logic [ABW-1:0]             base,
  input  logic [VDIM-1:0][WBW-1:0]   bofs,
  input  logic [VDIM-1:0][SBW-1:0]   shifts,
  output logic [ABW-1:0]             sum
);

  logic [ABW-1:0] sum_s;

  // Accumulate the zero-extended, shifted offsets of every dimension onto the base
  always_comb begin
    sum_s = base;
    for (int d = 0; d < VDIM; d++) begin
      sum_s = sum_s + (ABW'(bofs[d]) << shifts[d]);
    end
  end

  assign sum = sum_s;

endmodule

// File: rtl/accum_warp_looper_id_stage.sv
// Warp descriptor to per-config token expander: one token per active config,
// with retire/last released only on the final config of the warp.
module accum_warp_looper_id_stage
  import accum_warp_looper_id_stage_pkg::*;
#(
  parameter  int N_CFG   = N_ICFG,
  parameter  int ABW     = GLOBAL_ADDR_BW,
  localparam int WBW     = WORK_BW,
  localparam int NCFG_BW = $clog2(N_CFG + 1),
  localparam int SBW     = $clog2(ABW)
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              src_rdy,
  output logic                              src_ack,
  input  logic [VDIM-1:0][WBW-1:0]          i_bofs,
  input  logic                              i_retire,
  input  logic                              i_islast,
  input  logic [NCFG_BW-1:0]                i_id_end,
  input  logic [N_CFG-1:0][ABW-1:0]         i_linears,
  input  logic [N_CFG-1:0][VDIM-1:0][SBW-1:0] i_bshifts,
  input  logic [N_CFG-1:0]                  i_stencil_en,
  output logic                              dst_rdy,
  input  logic                              dst_ack,
  output logic [NCFG_BW-1:0]                o_id,
  output logic [ABW-1:0]                    o_linear,
  output logic [VDIM-1:0][WBW-1:0]          o_bofs,
  output logic                              o_retire,
  output logic                              o_islast,
  output logic                              o_stencil
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e                     state_r;
  logic [NCFG_BW-1:0]         id_r;
  logic [ABW-1:0]             linear_r;
  logic [VDIM-1:0][WBW-1:0]   bofs_r;
  logic                       retire_r;
  logic                       islast_r;

  logic                       busy_s;
  logic [NCFG_BW-1:0]         eff_end_s;
  logic                       id_last_s;
  logic                       src_ack_s;
  logic [NCFG_BW-1:0]         next_id_s;
  logic [NCFG_BW-1:0]         calc_id_s;
  logic [NCFG_BW-1:0]         sel_id_s;
  logic [NCFG_BW-1:0]         sten_id_s;
  logic [VDIM-1:0][WBW-1:0]   calc_bofs_s;
  logic [ABW-1:0]             calc_sum_s;

  // A zero config count is treated as one so a warp always yields a token
  assign eff_end_s = (i_id_end == '0) ? NCFG_BW'(1) : i_id_end;
  assign busy_s    = (state_r == ST_BUSY);
  assign id_last_s = (id_r == (eff_end_s - NCFG_BW'(1)));
  assign next_id_s = id_r + NCFG_BW'(1);
  assign src_ack_s = !i_rst && src_rdy && (!busy_s || (dst_ack && id_last_s));

  // Calculator operand mux: fresh warp at config 0, otherwise the next config
  always_comb begin
    calc_id_s   = '0;
    calc_bofs_s = '0;
    if (src_ack_s) begin
      calc_id_s   = '0;
      calc_bofs_s = i_bofs;
    end else begin
      calc_id_s   = next_id_s;
      calc_bofs_s = bofs_r;
    end
  end

  // Keep table lookups in range when the advance path is idle past the last config
  always_comb begin
    sel_id_s  = '0;
    sten_id_s = '0;
    if (calc_id_s < NCFG_BW'(N_CFG)) begin
      sel_id_s = calc_id_s;
    end else begin
      sel_id_s = '0;
    end
    if (id_r < NCFG_BW'(N_CFG)) begin
      sten_id_s = id_r;
    end else begin
      sten_id_s = '0;
    end
  end

  accum_warp_looper_linear_calc #(
    .ABW  (ABW),
    .WBW  (WBW),
    .VDIM (VDIM),
    .SBW  (SBW)
  ) u_linear_calc (
    .base   (i_linears[sel_id_s]),
    .bofs   (calc_bofs_s),
    .shifts (i_bshifts[sel_id_s]),
    .sum    (calc_sum_s)
  );

  // Token FSM: capture a warp, walk its configs, chain the next warp with no bubble
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r  <= ST_IDLE;
      id_r     <= '0;
      linear_r <= '0;
      bofs_r   <= '0;
      retire_r <= 1'b0;
      islast_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (src_ack_s) begin
            bofs_r   <= i_bofs;
            retire_r <= i_retire;
            islast_r <= i_islast;
            id_r     <= '0;
            linear_r <= calc_sum_s;
            state_r  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (dst_ack) begin
            if (!id_last_s) begin
              id_r     <= next_id_s;
              linear_r <= calc_sum_s;
            end else if (src_ack_s) begin
              bofs_r   <= i_bofs;
              retire_r <= i_retire;
              islast_r <= i_islast;
              id_r     <= '0;
              linear_r <= calc_sum_s;
            end else begin
              state_r  <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign src_ack   = src_ack_s;
  assign dst_rdy   = busy_s;
  assign o_id      = id_r;
  assign o_linear  = linear_r;
  assign o_bofs    = bofs_r;
  assign o_retire  = retire_r && id_last_s && busy_s;
  assign o_islast  = islast_r && id_last_s && busy_s;
  assign o_stencil = i_stencil_en[sten_id_s];

endmodule

// File: tb/tb_accum_warp_looper_id_stage.sv
// Bench for accum_warp_looper_id_stage: fixed vector table, hand-written
// stall/back-to-back/reset sequences, then randomized traffic against a token-queue model.
module tb_accum_warp_looper_id_stage;
  import accum_warp_looper_id_stage_pkg::*;

  localparam int NC  = N_ICFG;
  localparam int ABW = GLOBAL_ADDR_BW;
  localparam int WBW = WORK_BW;
  localparam int NB  = $clog2(NC + 1);
  localparam int SBW = $clog2(ABW);

  logic                            clk = 1'b0;
  logic                            i_rst;
  logic                            src_rdy;
  logic                            src_ack;
  logic [VDIM-1:0][WBW-1:0]        i_bofs;
  logic                            i_retire;
  logic                            i_islast;
  logic [NB-1:0]                   i_id_end;
  logic [NC-1:0][ABW-1:0]          i_linears;
  logic [NC-1:0][VDIM-1:0][SBW-1:0] i_bshifts;
  logic [NC-1:0]                   i_stencil_en;
  logic                            dst_rdy;
  logic                            dst_ack;
  logic [NB-1:0]                   o_id;
  logic [ABW-1:0]                  o_linear;
  logic [VDIM-1:0][WBW-1:0]        o_bofs;
  logic                            o_retire;
  logic                            o_islast;
  logic                            o_stencil;

  always #5 clk = ~clk;

  accum_warp_looper_id_stage dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .src_rdy      (src_rdy),
    .src_ack      (src_ack),
    .i_bofs       (i_bofs),
    .i_retire     (i_retire),
    .i_islast     (i_islast),
    .i_id_end     (i_id_end),
    .i_linears    (i_linears),
    .i_bshifts    (i_bshifts),
    .i_stencil_en (i_stencil_en),
    .dst_rdy      (dst_rdy),
    .dst_ack      (dst_ack),
    .o_id         (o_id),
    .o_linear     (o_linear),
    .o_bofs       (o_bofs),
    .o_retire     (o_retire),
    .o_islast     (o_islast),
    .o_stencil    (o_stencil)
  );

  typedef struct {
    logic [NB-1:0]                    id_end;
    logic [VDIM-1:0][WBW-1:0]         bofs;
    logic                             ret;
    logic                             last;
    logic [NC-1:0]                    sten;
    logic [NC-1:0][ABW-1:0]           lin;
    logic [NC-1:0][VDIM-1:0][SBW-1:0] sh;
    int                               ntok;
    logic [NC-1:0][ABW-1:0]           exp_lin;
    logic [NC-1:0]                    exp_ret;
    logic [NC-1:0]                    exp_last;
    logic [NC-1:0]                    exp_sten;
  } vec_t;

  typedef struct {
    int                       id;
    logic [ABW-1:0]           lin;
    logic [VDIM-1:0][WBW-1:0] bofs;
    logic                     ret;
    logic                     last;
    logic                     sten;
  } tok_t;

  vec_t vecs[5];
  tok_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input vec_t v);
    i_id_end     = v.id_end;
    i_bofs       = v.bofs;
    i_retire     = v.ret;
    i_islast     = v.last;
    i_stencil_en = v.sten;
    i_linears    = v.lin;
    i_bshifts    = v.sh;
  endtask

  // Accept one warp with dst_ack held high and compare every emitted token
  task automatic apply_vec(input int vi);
    vec_t v;
    v = vecs[vi];
    load_cfg(v);
    src_rdy = 1'b1;
    dst_ack = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d_src_ack", vi), 32'(src_ack), 32'd1);
    tick();
    src_rdy = 1'b0;
    for (int k = 0; k < v.ntok; k++) begin
      @(negedge clk);
      chk($sformatf("v%0d_t%0d_rdy", vi, k),    32'(dst_rdy),   32'd1);
      chk($sformatf("v%0d_t%0d_id", vi, k),     32'(o_id),      32'(k));
      chk($sformatf("v%0d_t%0d_linear", vi, k), 32'(o_linear),  32'(v.exp_lin[k]));
      chk($sformatf("v%0d_t%0d_bofs", vi, k),   32'(o_bofs),    32'(v.bofs));
      chk($sformatf("v%0d_t%0d_retire", vi, k), 32'(o_retire),  32'(v.exp_ret[k]));
      chk($sformatf("v%0d_t%0d_islast", vi, k), 32'(o_islast),  32'(v.exp_last[k]));
      chk($sformatf("v%0d_t%0d_stencil", vi, k), 32'(o_stencil), 32'(v.exp_sten[k]));
      tick();
    end
    @(negedge clk);
    chk($sformatf("v%0d_idle", vi), 32'(dst_rdy), 32'd0);
    tick();
  endtask

  function automatic logic [ABW-1:0] ref_calc(input int c, input logic [VDIM-1:0][WBW-1:0] b);
    longint s;
    s = longint'(i_linears[c]);
    for (int d = 0; d < VDIM; d++) begin
      s = s + longint'(b[d]) * (longint'(1) << i_bshifts[c][d]);
    end
    return ABW'(s);
  endfunction

  // One randomized cycle: predict handshake from the token queue, compare, update the queue
  task automatic rand_cycle(input logic s, input logic a);
    logic pred_ack;
    int   eff;
    tok_t t;
    src_rdy  = s;
    dst_ack  = a;
    i_bofs   = (VDIM*WBW)'($urandom);
    i_retire = 1'($urandom);
    i_islast = 1'($urandom);
    @(negedge clk);
    pred_ack = s && ((q.size() == 0) || (a && (q.size() == 1)));
    chk("rnd_dst_rdy", 32'(dst_rdy), (q.size() != 0) ? 32'd1 : 32'd0);
    chk("rnd_src_ack", 32'(src_ack), 32'(pred_ack));
    if (q.size() != 0) begin
      chk("rnd_id",      32'(o_id),      32'(q[0].id));
      chk("rnd_linear",  32'(o_linear),  32'(q[0].lin));
      chk("rnd_bofs",    32'(o_bofs),    32'(q[0].bofs));
      chk("rnd_retire",  32'(o_retire),  32'(q[0].ret));
      chk("rnd_islast",  32'(o_islast),  32'(q[0].last));
      chk("rnd_stencil", 32'(o_stencil), 32'(q[0].sten));
    end
    if (a && (q.size() != 0)) begin
      void'(q.pop_front());
    end
    if (pred_ack) begin
      eff = (i_id_end == '0) ? 1 : int'(i_id_end);
      for (int c = 0; c < eff; c++) begin
        t.id   = c;
        t.lin  = ref_calc(c, i_bofs);
        t.bofs = i_bofs;
        t.ret  = i_retire && (c == eff - 1);
        t.last = i_islast && (c == eff - 1);
        t.sten = i_stencil_en[c];
        q.push_back(t);
      end
    end
    tick();
  endtask

  initial begin
    int   b2b_id[8];
    logic b2b_rdy[8];
    logic b2b_ack[8];
    logic b2b_src[8];

    // Vector 0: nominal three-config warp
    vecs[0].id_end   = 2'd3;
    vecs[0].bofs     = {8'd1, 8'd2};
    vecs[0].ret      = 1'b1;
    vecs[0].last     = 1'b1;
    vecs[0].sten     = 3'b101;
    vecs[0].lin      = {16'h0300, 16'h0200, 16'h0100};
    vecs[0].sh       = {4'd0, 4'd0, 4'd5, 4'd1, 4'd4, 4'd0};
    vecs[0].ntok     = 3;
    vecs[0].exp_lin  = {16'h0303, 16'h0224, 16'h0112};
    vecs[0].exp_ret  = 3'b100;
    vecs[0].exp_last = 3'b100;
    vecs[0].exp_sten = 3'b101;
    // Vector 1: zero config count clamps to one token
    vecs[1]          = vecs[0];
    vecs[1].id_end   = 2'd0;
    vecs[1].last     = 1'b0;
    vecs[1].ntok     = 1;
    vecs[1].exp_ret  = 3'b001;
    vecs[1].exp_last = 3'b000;
    // Vector 2: single config
    vecs[2]          = vecs[0];
    vecs[2].id_end   = 2'd1;
    vecs[2].ret      = 1'b0;
    vecs[2].ntok     = 1;
    vecs[2].exp_ret  = 3'b000;
    vecs[2].exp_last = 3'b001;
    // Vector 3: address wrap and stencil selection
    vecs[3].id_end   = 2'd3;
    vecs[3].bofs     = {8'd0, 8'd1};
    vecs[3].ret      = 1'b1;
    vecs[3].last     = 1'b0;
    vecs[3].sten     = 3'b010;
    vecs[3].lin      = {16'hFFFF, 16'hFFFF, 16'hFFFF};
    vecs[3].sh       = '0;
    vecs[3].ntok     = 3;
    vecs[3].exp_lin  = {16'h0000, 16'h0000, 16'h0000};
    vecs[3].exp_ret  = 3'b100;
    vecs[3].exp_last = 3'b000;
    vecs[3].exp_sten = 3'b010;
    // Vector 4: two configs, different offsets
    vecs[4]          = vecs[0];
    vecs[4].id_end   = 2'd2;
    vecs[4].bofs     = {8'd5, 8'd3};
    vecs[4].last     = 1'b0;
    vecs[4].ntok     = 2;
    vecs[4].exp_lin  = {16'h0000, 16'h02A6, 16'h0153};
    vecs[4].exp_ret  = 3'b010;
    vecs[4].exp_last = 3'b000;

    i_rst        = 1'b1;
    src_rdy      = 1'b1;
    dst_ack      = 1'b0;
    i_bofs       = '0;
    i_retire     = 1'b0;
    i_islast     = 1'b0;
    i_id_end     = 2'd3;
    i_linears    = '0;
    i_bshifts    = '0;
    i_stencil_en = 3'b001;

    @(negedge clk);
    chk("rst_src_ack", 32'(src_ack), 32'd0);
    tick();
    tick();
    i_rst   = 1'b0;
    src_rdy = 1'b0;
    @(negedge clk);
    chk("rst_dst_rdy", 32'(dst_rdy),   32'd0);
    chk("rst_id",      32'(o_id),      32'd0);
    chk("rst_linear",  32'(o_linear),  32'd0);
    chk("rst_bofs",    32'(o_bofs),    32'd0);
    chk("rst_retire",  32'(o_retire),  32'd0);
    chk("rst_islast",  32'(o_islast),  32'd0);
    chk("rst_stencil", 32'(o_stencil), 32'd1);
    tick();

    for (int i = 0; i < 5; i++) begin
      apply_vec(i);
    end

    // Stall on id 1 for three cycles with a new warp pending
    load_cfg(vecs[0]);
    src_rdy = 1'b1;
    dst_ack = 1'b1;
    tick();
    src_rdy = 1'b0;
    @(negedge clk);
    chk("stall_id0", 32'(o_id), 32'd0);
    tick();
    dst_ack = 1'b0;
    src_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_rdy",     32'(dst_rdy),  32'd1);
      chk("stall_id",      32'(o_id),     32'd1);
      chk("stall_linear",  32'(o_linear), 32'h0224);
      chk("stall_src_ack", 32'(src_ack),  32'd0);
      tick();
    end
    dst_ack = 1'b1;
    src_rdy = 1'b0;
    @(negedge clk);
    chk("resume_id1", 32'(o_id), 32'd1);
    tick();
    @(negedge clk);
    chk("resume_id2",     32'(o_id),     32'd2);
    chk("resume_linear2", 32'(o_linear), 32'h0303);
    chk("resume_retire2", 32'(o_retire), 32'd1);
    tick();
    @(negedge clk);
    chk("resume_idle", 32'(dst_rdy), 32'd0);
    tick();

    // Two warps back to back with no bubble
    b2b_id  = '{0, 0, 1, 2, 0, 1, 2, 0};
    b2b_rdy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    b2b_ack = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    b2b_src = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    dst_ack = 1'b1;
    for (int c = 0; c < 8; c++) begin
      src_rdy = b2b_src[c];
      @(negedge clk);
      chk($sformatf("b2b_c%0d_rdy", c),     32'(dst_rdy), 32'(b2b_rdy[c]));
      chk($sformatf("b2b_c%0d_src_ack", c), 32'(src_ack), 32'(b2b_ack[c]));
      if (b2b_rdy[c]) begin
        chk($sformatf("b2b_c%0d_id", c), 32'(o_id), 32'(b2b_id[c]));
      end
      tick();
    end

    // Reset while holding id 1; reset must beat a pending src_rdy
    src_rdy = 1'b1;
    tick();
    src_rdy = 1'b0;
    tick();
    dst_ack = 1'b0;
    i_rst   = 1'b1;
    src_rdy = 1'b1;
    @(negedge clk);
    chk("mid_rst_id",      32'(o_id),    32'd1);
    chk("mid_rst_src_ack", 32'(src_ack), 32'd0);
    tick();
    i_rst   = 1'b0;
    src_rdy = 1'b0;
    dst_ack = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy",    32'(dst_rdy),  32'd0);
    chk("post_rst_id",     32'(o_id),     32'd0);
    chk("post_rst_linear", 32'(o_linear), 32'd0);
    chk("post_rst_bofs",   32'(o_bofs),   32'd0);
    chk("post_rst_retire", 32'(o_retire), 32'd0);
    chk("post_rst_islast", 32'(o_islast), 32'd0);
    tick();
    apply_vec(0);

    // Randomized traffic, config changed only between drained epochs
    for (int e = 0; e < 20; e++) begin
      i_id_end     = NB'($urandom_range(0, NC));
      i_linears    = (NC*ABW)'({$urandom, $urandom});
      i_bshifts    = (NC*VDIM*SBW)'($urandom);
      i_stencil_en = NC'($urandom);
      for (int c = 0; c < 30; c++) begin
        rand_cycle(1'($urandom), ($urandom_range(0, 3) != 0));
      end
      for (int c = 0; c < 4; c++) begin
        rand_cycle(1'b0, 1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
